// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
// Latency: none (declarations only).
// Backpressure: not applicable.
package keypad_pkg;

  // Key code meaning "no key pressed".
  localparam int KEY_NONE = 0;

  // Scan sequencer states: drive a column, sample it, or first dwell clock after a frame closes.
  typedef enum logic [1:0] {
    ST_DRIVE,
    ST_SAMPLE,
    ST_FRAME_END
  } scan_state_t;

  // Width that holds every key code 1..rows*cols plus the "none" code 0.
  function automatic int code_width(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: accepts a code after DEBOUNCE_FRAMES identical frames.
// Latency: key_code/key_multi update on the frame_vld clock that completes the run.
// Backpressure: none; key_new is a one-clock strobe that the consumer must latch.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int CODE_W          = 5,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_vld,
  input  logic [CODE_W-1:0] frame_code,
  input  logic              frame_multi,
  output logic [CODE_W-1:0] key_code,
  output logic              key_multi,
  output logic              key_new
);

  localparam int STB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE_FRAMES);

  logic [CODE_W-1:0] candidate;
  logic [CODE_W-1:0] cand_nxt;
  logic [STB_W-1:0]  stable;
  logic [STB_W-1:0]  stable_nxt;
  logic              load;

  // Next candidate/run length, and whether this frame commits a new key code.
  always_comb begin
    cand_nxt   = candidate;
    stable_nxt = stable;
    if (frame_code == candidate) begin
      if (stable != STB_MAX) stable_nxt = stable + STB_W'(1);
    end else begin
      cand_nxt   = frame_code;
      stable_nxt = STB_W'(1);
    end
    load    = frame_vld && (stable_nxt == STB_MAX) && (cand_nxt != key_code);
    // Only a change to a real key is reported; releases are silent.
    key_new = load && (cand_nxt != CODE_W'(KEY_NONE));
  end

  // Candidate tracking and committed key state, updated once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate <= '0;
      stable    <= '0;
      key_code  <= '0;
      key_multi <= 1'b0;
    end else if (frame_vld) begin
      candidate <= cand_nxt;
      stable    <= stable_nxt;
      if (load) begin
        key_code  <= cand_nxt;
        key_multi <= frame_multi;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Scans an R x C key matrix, debounces it and hands new key-downs to the CPU (KEYPAD_ACTIVE_LOW_EN: active-low pins).
// Latency: clean press reaches Key_Valid within (DEBOUNCE_FRAMES+1) frames + 3 clocks.
// Backpressure: Key_Valid holds until Key_Ack; a newer key while pending overwrites Key_Code and sets sticky Key_Overrun.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int   NUM_ROWS        = 4,
  parameter int   NUM_COLS        = 6,
  parameter int   SCAN_DIV        = 4,
  parameter int   DEBOUNCE_FRAMES = 3,
  localparam int  CODE_W          = code_width(NUM_ROWS, NUM_COLS)
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [NUM_ROWS-1:0] Keyb_Row_I,
  output logic [NUM_COLS-1:0] Keyb_Col_O,
  output logic [CODE_W-1:0]   Key_Code,
  output logic                Key_Valid,
  input  logic                Key_Ack,
  output logic                Key_Multi,
  output logic                Key_Overrun
);

  localparam int COL_W = idx_width(NUM_COLS);
  localparam int DIV_W = idx_width(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(SCAN_DIV - 2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] row_in;
  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [NUM_COLS-1:0] col_oh;

  // Pin polarity is resolved at the edges so all internal logic is active-high.
`ifdef KEYPAD_ACTIVE_LOW_EN
  localparam logic [NUM_ROWS-1:0] SYNC_RST = '1;
  assign row_in     = ~Keyb_Row_I;
  assign Keyb_Col_O = ~col_oh;
`else
  localparam logic [NUM_ROWS-1:0] SYNC_RST = '0;
  assign row_in     = Keyb_Row_I;
  assign Keyb_Col_O = col_oh;
`endif

  // Two-flop synchroniser on the asynchronous row returns.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      row_meta <= SYNC_RST;
      row_sync <= SYNC_RST;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  scan_state_t         state;
  logic [DIV_W-1:0]    div;
  logic [COL_W-1:0]    col;
  logic [CODE_W-1:0]   acc_code;
  logic                acc_multi;
  logic [CODE_W-1:0]   sample_code;
  logic                sample_multi;
  logic                frame_vld;
  logic [CODE_W-1:0]   frame_code;
  logic                frame_multi;

  // Encode the current column's sample: lowest set row wins; a second hit anywhere marks multi.
  always_comb begin
    sample_code = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (row_sync[r]) sample_code = CODE_W'(int'(col) * NUM_ROWS + r + 1);
    end
    sample_multi = ((row_sync != '0) && (acc_code != '0)) ||
                   ((row_sync & (row_sync - NUM_ROWS'(1))) != '0);
  end

  // Column sequencer: dwell SCAN_DIV clocks per column, sample on the last, close the frame after the last column.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_DRIVE;
      div         <= '0;
      col         <= '0;
      col_oh      <= NUM_COLS'(1);
      acc_code    <= '0;
      acc_multi   <= 1'b0;
      frame_vld   <= 1'b0;
      frame_code  <= '0;
      frame_multi <= 1'b0;
    end else begin
      frame_vld <= 1'b0;
      case (state)
        ST_DRIVE, ST_FRAME_END: begin
          div   <= div + DIV_W'(1);
          state <= (div == DIV_PRE) ? ST_SAMPLE : ST_DRIVE;
        end
        ST_SAMPLE: begin
          div <= '0;
          if (col == COL_LAST) begin
            col         <= '0;
            col_oh      <= NUM_COLS'(1);
            frame_vld   <= 1'b1;
            frame_code  <= (acc_code != '0) ? acc_code : sample_code;
            frame_multi <= acc_multi | sample_multi;
            acc_code    <= '0;
            acc_multi   <= 1'b0;
            state       <= ST_FRAME_END;
          end else begin
            col       <= col + COL_W'(1);
            col_oh    <= col_oh << 1;
            if (acc_code == '0) acc_code <= sample_code;
            acc_multi <= acc_multi | sample_multi;
            state     <= ST_DRIVE;
          end
        end
        default: state <= ST_DRIVE;
      endcase
    end
  end

  logic key_new;

  keypad_debounce #(
    .CODE_W          (CODE_W),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk         (Clock),
    .rst_n       (Reset_n),
    .frame_vld   (frame_vld),
    .frame_code  (frame_code),
    .frame_multi (frame_multi),
    .key_code    (Key_Code),
    .key_multi   (Key_Multi),
    .key_new     (key_new)
  );

  // Event handshake: a new key wins over a same-clock ack; an unacked overwrite is flagged until acked.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Key_Valid   <= 1'b0;
      Key_Overrun <= 1'b0;
    end else begin
      if (Key_Valid && Key_Ack) Key_Overrun <= 1'b0;
      if (key_new) begin
        Key_Valid <= 1'b1;
        if (Key_Valid && !Key_Ack) Key_Overrun <= 1'b1;
      end else if (Key_Ack) begin
        Key_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: default instance plus a 3x8, SCAN_DIV=5 instance.
// Latency: waits are bounded by the documented press-to-valid limit.
// Backpressure: acks are driven explicitly per step.
module tb_keypad_matrix_scanner;

`ifdef KEYPAD_ACTIVE_LOW_EN
  localparam bit ACT_LOW = 1'b1;
`else
  localparam bit ACT_LOW = 1'b0;
`endif

  localparam int AR = 4, AC = 6;
  localparam int BR = 3, BC = 8;
  localparam int LAT_A = 4 * 24 + 3;
  localparam int LAT_B = 4 * 40 + 3;

  logic Clock = 1'b0;
  logic Reset_n;
  always #5 Clock = ~Clock;

  logic [AR-1:0] row_a, row_a_act;
  logic [AC-1:0] col_a, col_a_act;
  logic [4:0]    code_a;
  logic          valid_a, ack_a, multi_a, ovr_a;
  logic [AR*AC-1:0] keys_a;

  logic [BR-1:0] row_b, row_b_act;
  logic [BC-1:0] col_b, col_b_act;
  logic [4:0]    code_b;
  logic          valid_b, ack_b, multi_b, ovr_b;
  logic [BR*BC-1:0] keys_b;

  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  logic prev_valid = 1'b0;

  keypad_matrix_scanner dut_a (
    .Clock(Clock), .Reset_n(Reset_n), .Keyb_Row_I(row_a), .Keyb_Col_O(col_a),
    .Key_Code(code_a), .Key_Valid(valid_a), .Key_Ack(ack_a), .Key_Multi(multi_a),
    .Key_Overrun(ovr_a)
  );

  keypad_matrix_scanner #(.NUM_ROWS(BR), .NUM_COLS(BC), .SCAN_DIV(5)) dut_b (
    .Clock(Clock), .Reset_n(Reset_n), .Keyb_Row_I(row_b), .Keyb_Col_O(col_b),
    .Key_Code(code_b), .Key_Valid(valid_b), .Key_Ack(ack_b), .Key_Multi(multi_b),
    .Key_Overrun(ovr_b)
  );

  // Key matrix model: a pressed key connects its column drive to its row return.
  assign col_a_act = ACT_LOW ? ~col_a : col_a;
  assign col_b_act = ACT_LOW ? ~col_b : col_b;
  always_comb begin
    row_a_act = '0;
    for (int c = 0; c < AC; c++)
      for (int r = 0; r < AR; r++)
        if (col_a_act[c] && keys_a[c*AR+r]) row_a_act[r] = 1'b1;
    row_b_act = '0;
    for (int c = 0; c < BC; c++)
      for (int r = 0; r < BR; r++)
        if (col_b_act[c] && keys_b[c*BR+r]) row_b_act[r] = 1'b1;
  end
  assign row_a = ACT_LOW ? ~row_a_act : row_a_act;
  assign row_b = ACT_LOW ? ~row_b_act : row_b_act;

  // Count rising edges of Key_Valid on the default instance.
  always @(negedge Clock) begin
    if (valid_a && !prev_valid) ev_cnt++;
    prev_valid = valid_a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic wait_valid(input bit use_b, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge Clock);
      if (use_b ? valid_b : valid_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_code_a(input logic [4:0] code, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge Clock);
      if (code_a == code) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_pulse(input bit use_b);
    if (use_b) ack_b = 1'b1; else ack_a = 1'b1;
    @(negedge Clock);
    ack_a = 1'b0;
    ack_b = 1'b0;
  endtask

  // Clocks between successive activations of column 0; -1 on timeout.
  task automatic measure_period(input bit use_b, output int period);
    logic prev, cur;
    int   first;
    period = -1;
    first  = -1;
    prev   = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge Clock);
      cur = use_b ? col_b_act[0] : col_a_act[0];
      if (cur && !prev) begin
        if (first < 0) first = n;
        else begin
          period = n - first;
          break;
        end
      end
      prev = cur;
    end
  endtask

  initial begin
    bit ok;
    int period;
    int ev0;
    logic [AC-1:0] col_rst;
    logic [BC-1:0] col_rst_b;
    col_rst   = ACT_LOW ? ~AC'(1) : AC'(1);
    col_rst_b = ACT_LOW ? ~BC'(1) : BC'(1);

    Reset_n = 1'b0;
    ack_a = 1'b0;
    ack_b = 1'b0;
    keys_a = '0;
    keys_b = '0;
    #12;
    check("rst_col", col_a, col_rst);
    check("rst_code", code_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_multi", multi_a, 0);
    check("rst_overrun", ovr_a, 0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Frame period of the default build.
    measure_period(1'b0, period);
    check("period_a", period, 24);

    // Single press col 2 row 1 -> code 10.
    keys_a[9] = 1'b1;
    wait_valid(1'b0, LAT_A, ok);
    check("press_latency", ok, 1);
    check("press_code", code_a, 10);
    check("press_multi", multi_a, 0);
    ack_pulse(1'b0);
    check("ack_clears_valid", valid_a, 0);
    ev0 = ev_cnt;
    keys_a = '0;
    wait_code_a(5'd0, LAT_A, ok);
    check("release_code", ok, 1);
    cycles(30);
    check("release_no_event", ev_cnt, ev0);
    check("release_valid", valid_a, 0);

    // Bounce on code 1: toggle every 20 clocks for 200 clocks, then hold.
    ev0 = ev_cnt;
    for (int i = 0; i < 10; i++) begin
      keys_a[0] = (i % 2 == 0);
      cycles(20);
    end
    check("bounce_no_event", ev_cnt, ev0);
    keys_a[0] = 1'b1;
    wait_valid(1'b0, LAT_A, ok);
    check("bounce_latency", ok, 1);
    check("bounce_code", code_a, 1);
    cycles(100);
    check("bounce_one_event", ev_cnt, ev0 + 1);
    ack_pulse(1'b0);
    keys_a = '0;
    wait_code_a(5'd0, LAT_A, ok);
    check("bounce_release", ok, 1);

    // Two keys together: codes 5 and 14.
    keys_a[4]  = 1'b1;
    keys_a[13] = 1'b1;
    wait_valid(1'b0, LAT_A, ok);
    check("multi_latency", ok, 1);
    check("multi_code", code_a, 5);
    check("multi_flag", multi_a, 1);
    ack_pulse(1'b0);
    keys_a = '0;
    wait_code_a(5'd0, LAT_A, ok);
    check("multi_release", ok, 1);
    check("multi_flag_release", multi_a, 0);

    // Overrun: press 3, leave it unacked, release, press 7.
    keys_a[2] = 1'b1;
    wait_valid(1'b0, LAT_A, ok);
    check("ovr_first_latency", ok, 1);
    check("ovr_first_code", code_a, 3);
    keys_a = '0;
    wait_code_a(5'd0, LAT_A, ok);
    check("ovr_release", ok, 1);
    check("ovr_still_pending", valid_a, 1);
    check("ovr_not_yet", ovr_a, 0);
    keys_a[6] = 1'b1;
    wait_code_a(5'd7, LAT_A, ok);
    check("ovr_second_code", ok, 1);
    check("ovr_valid", valid_a, 1);
    check("ovr_flag", ovr_a, 1);
    ack_pulse(1'b0);
    check("ovr_ack_valid", valid_a, 0);
    check("ovr_ack_flag", ovr_a, 0);
    keys_a = '0;
    wait_code_a(5'd0, LAT_A, ok);
    check("ovr_final_release", ok, 1);

    // Reset mid-scan with an event pending.
    keys_a[9] = 1'b1;
    wait_valid(1'b0, LAT_A, ok);
    check("mid_rst_setup", ok, 1);
    cycles(5);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_col", col_a, col_rst);
    check("mid_rst_col_b", col_b, col_rst_b);
    check("mid_rst_code", code_a, 0);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_overrun", ovr_a, 0);
    keys_a = '0;
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    ev0 = ev_cnt;
    cycles(120);
    check("mid_rst_discarded", ev_cnt, ev0);
    check("mid_rst_code_after", code_a, 0);

    // 3x8 instance with SCAN_DIV=5: col 7 row 2 -> code 24.
    measure_period(1'b1, period);
    check("period_b", period, 40);
    keys_b[23] = 1'b1;
    wait_valid(1'b1, LAT_B, ok);
    check("b_latency", ok, 1);
    check("b_code", code_b, 24);
    check("b_multi", multi_b, 0);
    ack_pulse(1'b1);
    check("b_ack", valid_b, 0);
    keys_b = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
